// File: rtl/arm_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : arm_mem_responder
//  Brief    : Single-port word memory slave with valid/ready request and
//             response channels and a fixed number of wait states.
//  Revision : 1.0 - initial release
// ============================================================================
module arm_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int         c_aw   = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_wait = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state, w_state;
  logic [3:0]  r_cnt, w_cnt;
  logic [31:0] r_addr;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_req_ready, w_req_ready;
  logic        r_resp_valid, w_resp_valid;
  logic [31:0] r_resp_rdata, w_resp_rdata;
  logic        r_resp_err, w_resp_err;
  logic        r_busy, w_busy;
  logic        w_latch;
  logic        w_access;
  logic        w_dec_err;
  logic [c_aw-1:0] w_idx;

  logic [31:0] r_mem [DEPTH_WORDS];

  // Any set bit above the word-index field is out of range; nothing aliases.
  assign w_idx     = r_addr[c_aw+1:2];
  assign w_dec_err = (r_addr[1:0] != 2'b00) || (r_addr[31:c_aw+2] != '0);

  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_req_ready  = r_req_ready;
    w_resp_valid = r_resp_valid;
    w_resp_rdata = r_resp_rdata;
    w_resp_err   = r_resp_err;
    w_busy       = r_busy;
    w_latch      = 1'b0;
    w_access     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid && r_req_ready) begin
          w_latch     = 1'b1;
          w_req_ready = 1'b0;
          w_busy      = 1'b1;
          w_cnt       = c_wait;
          w_state     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Counter at zero marks the access edge, giving WAIT_CYCLES+1 latency.
        if (r_cnt == 4'd0) begin
          w_access     = 1'b1;
          w_state      = ST_RESP;
          w_resp_valid = 1'b1;
          w_resp_err   = w_dec_err;
          w_resp_rdata = (w_dec_err || r_we) ? 32'h0 : r_mem[w_idx];
        end else begin
          w_cnt = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          w_state      = ST_IDLE;
          w_resp_valid = 1'b0;
          w_req_ready  = 1'b1;
          w_busy       = 1'b0;
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_addr       <= 32'h0;
      r_we         <= 1'b0;
      r_wdata      <= 32'h0;
      r_be         <= 4'h0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_req_ready  <= w_req_ready;
      r_resp_valid <= w_resp_valid;
      r_resp_rdata <= w_resp_rdata;
      r_resp_err   <= w_resp_err;
      r_busy       <= w_busy;
      if (w_latch) begin
        r_addr  <= req_addr;
        r_we    <= req_we;
        r_wdata <= req_wdata;
        r_be    <= req_be;
      end
    end
  end

  // Storage is deliberately not reset; an aborted transaction never reaches w_access.
  always_ff @(posedge clk) begin
    if (w_access && !w_dec_err && r_we) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign busy       = r_busy;

endmodule
`default_nettype wire
